// File: rtl/cdb_broadcast_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module   : cdb_broadcast_arbiter_if                                        |
// | Brief    : Functional-unit result handshake and CDB broadcast bundle.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cdb_broadcast_arbiter_if #(
   parameter int N_UNITS = 4,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 6
);
   logic [N_UNITS-1:0]        unit_valid;
   logic [N_UNITS-1:0]        unit_ready;
   logic [N_UNITS*TAG_W-1:0]  unit_tag;
   logic [N_UNITS*DATA_W-1:0] unit_data;
   logic                      cdb_data_valid;
   logic [TAG_W-1:0]          cdb_tag;
   logic [DATA_W-1:0]         cdb_data;

   // Functional units plus bus snoopers
   modport master (
      output unit_valid, unit_tag, unit_data,
      input  unit_ready, cdb_data_valid, cdb_tag, cdb_data
   );

   // Arbiter side
   modport slave (
      input  unit_valid, unit_tag, unit_data,
      output unit_ready, cdb_data_valid, cdb_tag, cdb_data
   );
endinterface

`default_nettype wire

// File: rtl/cdb_broadcast_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : cdb_broadcast_arbiter                                           |
// | Brief    : Round-robin CDB transmitter with a one-deep buffer per unit.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdb_broadcast_arbiter #(
   parameter int N_UNITS = 4,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   cdb_broadcast_arbiter_if.slave  bus
);

   localparam int c_PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

   logic [N_UNITS-1:0] r_buf_valid;
   logic [TAG_W-1:0]   r_buf_tag  [N_UNITS];
   logic [DATA_W-1:0]  r_buf_data [N_UNITS];
   logic [c_PTR_W-1:0] r_ptr;
   logic               r_cdb_valid;
   logic [TAG_W-1:0]   r_cdb_tag;
   logic [DATA_W-1:0]  r_cdb_data;

   logic [N_UNITS-1:0] w_grant;
   logic [N_UNITS-1:0] w_accept;
   logic [c_PTR_W-1:0] w_win;
   logic [c_PTR_W-1:0] w_ptr_nxt;
   logic               w_any;

   // Two passes: indices at/after the pointer first, then the wrapped ones.
   always_comb begin
      w_grant = '0;
      w_win   = '0;
      w_any   = 1'b0;
      for (int i = 0; i < N_UNITS; i++) begin
         if (!w_any && r_buf_valid[i] && (i >= int'(r_ptr))) begin
            w_any = 1'b1;
            w_win = c_PTR_W'(i);
         end
      end
      for (int i = 0; i < N_UNITS; i++) begin
         if (!w_any && r_buf_valid[i] && (i < int'(r_ptr))) begin
            w_any = 1'b1;
            w_win = c_PTR_W'(i);
         end
      end
      if (flush) begin
         w_any = 1'b0;
      end else if (w_any) begin
         w_grant[w_win] = 1'b1;
      end
   end

   assign w_ptr_nxt = (int'(w_win) == N_UNITS - 1) ? '0 : w_win + 1'b1;

   // A draining buffer can take a new result on the same edge.
   assign bus.unit_ready = {N_UNITS{rst & ~flush}} & (~r_buf_valid | w_grant);
   assign w_accept       = bus.unit_valid & bus.unit_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_buf_valid <= '0;
         r_ptr       <= '0;
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= '0;
         r_cdb_data  <= '0;
      end else if (flush) begin
         r_buf_valid <= '0;
         r_cdb_valid <= 1'b0;
      end else begin
         for (int i = 0; i < N_UNITS; i++) begin
            if (w_accept[i]) begin
               r_buf_valid[i] <= 1'b1;
               r_buf_tag[i]   <= bus.unit_tag[i*TAG_W +: TAG_W];
               r_buf_data[i]  <= bus.unit_data[i*DATA_W +: DATA_W];
            end else if (w_grant[i]) begin
               r_buf_valid[i] <= 1'b0;
            end
         end
         if (w_any) begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= r_buf_tag[w_win];
            r_cdb_data  <= r_buf_data[w_win];
            r_ptr       <= w_ptr_nxt;
         end else begin
            r_cdb_valid <= 1'b0;
         end
      end
   end

   assign bus.cdb_data_valid = r_cdb_valid;
   assign bus.cdb_tag        = r_cdb_tag;
   assign bus.cdb_data       = r_cdb_data;

endmodule

`default_nettype wire

// File: tb/tb_cdb_broadcast_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_cdb_broadcast_arbiter                                        |
// | Brief    : Directed vector bench for the CDB broadcast arbiter.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cdb_broadcast_arbiter;

   logic clk;
   logic rst;
   logic flush;

   int n_checks;
   int n_errors;

   cdb_broadcast_arbiter_if #(.N_UNITS(4), .DATA_W(32), .TAG_W(6)) bus ();

   cdb_broadcast_arbiter #(.N_UNITS(4), .DATA_W(32), .TAG_W(6)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic            fl;
      logic [3:0]      v;
      logic [3:0][5:0] t;
      logic [3:0]      er;
      logic            ecv;
      logic [5:0]      etag;
   } vec_t;

   vec_t tbl[$];

   // Table rows derive each unit's data from its tag
   function automatic logic [31:0] dval(input logic [5:0] t);
      return 32'(t) * 32'h0101_0101;
   endfunction

   function automatic vec_t mkv(input logic fl, input logic [3:0] v,
                                input logic [5:0] t3, input logic [5:0] t2,
                                input logic [5:0] t1, input logic [5:0] t0,
                                input logic [3:0] er, input logic ecv,
                                input logic [5:0] etag);
      vec_t r;
      r.fl = fl; r.v = v; r.t = {t3, t2, t1, t0};
      r.er = er; r.ecv = ecv; r.etag = etag;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic f, input logic [3:0] v,
                        input logic [3:0][5:0] t, input logic [3:0][31:0] d);
      flush          = f;
      bus.unit_valid = v;
      bus.unit_tag   = t;
      bus.unit_data  = d;
   endtask

   task automatic idle();
      drive(1'b0, 4'b0000, '0, '0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cdb(input string nm, input logic v, input logic [5:0] t,
                          input logic [31:0] d);
      chk({nm, ".valid"}, 32'(bus.cdb_data_valid), 32'(v));
      chk({nm, ".tag"},   32'(bus.cdb_tag), 32'(t));
      chk({nm, ".data"},  bus.cdb_data, d);
   endtask

   initial begin
      logic [3:0][31:0] d;
      logic [3:0][5:0]  t;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      idle();

      // All-unit contention from ptr=0, then wrap of the round-robin pointer
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b1111, 0, 6'h00));
      tbl.push_back(mkv(0, 4'b1111, 6'h04, 6'h03, 6'h02, 6'h01, 4'b1111, 0, 6'h00));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b0001, 1, 6'h01));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b0011, 1, 6'h02));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b0111, 1, 6'h03));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b1111, 1, 6'h04));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b1111, 0, 6'h04));
      tbl.push_back(mkv(0, 4'b0010, 6'h00, 6'h00, 6'h11, 6'h00, 4'b1111, 0, 6'h04));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b1111, 1, 6'h11));
      tbl.push_back(mkv(0, 4'b1001, 6'h33, 6'h00, 6'h00, 6'h30, 4'b1111, 0, 6'h11));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b1110, 1, 6'h33));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b1111, 1, 6'h30));
      tbl.push_back(mkv(0, 4'b1111, 6'h24, 6'h23, 6'h22, 6'h21, 4'b1111, 0, 6'h30));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b0010, 1, 6'h22));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b0110, 1, 6'h23));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b1110, 1, 6'h24));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b1111, 1, 6'h21));
      tbl.push_back(mkv(0, 4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 4'b1111, 0, 6'h21));

      tick();
      tick();
      chk("rst.ready", 32'(bus.unit_ready), 32'h0);
      chk_cdb("rst", 1'b0, 6'h00, 32'h0);
      rst = 1'b1;

      foreach (tbl[k]) begin
         for (int u = 0; u < 4; u++) d[u] = dval(tbl[k].t[u]);
         drive(tbl[k].fl, tbl[k].v, tbl[k].t, d);
         #1;
         chk($sformatf("vec%0d.ready", k), 32'(bus.unit_ready), 32'(tbl[k].er));
         tick();
         chk_cdb($sformatf("vec%0d", k), tbl[k].ecv, tbl[k].etag, dval(tbl[k].etag));
      end

      // Single unit: 2-edge latency, one-cycle pulse
      t = '0; d = '0; t[2] = 6'h15; d[2] = 32'hDEAD_BEEF;
      drive(1'b0, 4'b0100, t, d);
      #1;
      chk("single.ready0", 32'(bus.unit_ready[2]), 32'h1);
      tick();
      chk_cdb("single.e0", 1'b0, 6'h21, dval(6'h21));
      idle();
      #1;
      chk("single.ready1", 32'(bus.unit_ready[2]), 32'h1);
      tick();
      chk_cdb("single.e1", 1'b1, 6'h15, 32'hDEAD_BEEF);
      #1;
      chk("single.ready2", 32'(bus.unit_ready[2]), 32'h1);
      tick();
      chk_cdb("single.e2", 1'b0, 6'h15, 32'hDEAD_BEEF);

      // Back-to-back from unit 0 with same-edge refill
      for (int k = 0; k < 7; k++) begin
         t = '0; d = '0;
         t[0] = 6'(6'h20 + k);
         d[0] = 32'(10 + k);
         drive(1'b0, (k < 5) ? 4'b0001 : 4'b0000, t, d);
         #1;
         chk($sformatf("b2b%0d.ready", k), 32'(bus.unit_ready[0]), 32'h1);
         tick();
         if (k >= 1 && k <= 5)
            chk_cdb($sformatf("b2b%0d", k), 1'b1, 6'(6'h20 + k - 1), 32'(10 + k - 1));
         else
            chk($sformatf("b2b%0d.valid", k), 32'(bus.cdb_data_valid), 32'h0);
      end

      // Flush with units 1 and 3 buffered and unit 0 handshaking
      t = '0; d = '0; t[1] = 6'h31; t[3] = 6'h33; d[1] = 32'h1111; d[3] = 32'h3333;
      drive(1'b0, 4'b1010, t, d);
      tick();
      chk("flush.pre.valid", 32'(bus.cdb_data_valid), 32'h0);
      t = '0; d = '0; t[0] = 6'h30; d[0] = 32'h5A5A;
      drive(1'b1, 4'b0001, t, d);
      #1;
      chk("flush.ready", 32'(bus.unit_ready), 32'h0);
      tick();
      chk_cdb("flush.e0", 1'b0, 6'h24, 32'd14);
      idle();
      #1;
      chk("flush.after.ready", 32'(bus.unit_ready), 32'hF);
      tick();
      chk("flush.e1.valid", 32'(bus.cdb_data_valid), 32'h0);
      tick();
      chk("flush.e2.valid", 32'(bus.cdb_data_valid), 32'h0);

      // Reset mid-stream with three buffers full
      for (int u = 0; u < 4; u++) begin
         t[u] = 6'(6'h41 + u);
         d[u] = dval(t[u]);
      end
      drive(1'b0, 4'b1111, t, d);
      tick();
      idle();
      tick();
      chk_cdb("mid.bcast", 1'b1, 6'h42, dval(6'h42));
      rst = 1'b0;
      #1;
      chk("mid.rst.ready", 32'(bus.unit_ready), 32'h0);
      tick();
      chk_cdb("mid.rst", 1'b0, 6'h00, 32'h0);
      rst = 1'b1;
      #1;
      chk("mid.rel.ready", 32'(bus.unit_ready), 32'hF);
      tick();
      chk("mid.rel.valid", 32'(bus.cdb_data_valid), 32'h0);
      for (int u = 0; u < 4; u++) begin
         t[u] = 6'(6'h51 + u);
         d[u] = dval(t[u]);
      end
      drive(1'b0, 4'b1111, t, d);
      tick();
      chk("post.load.valid", 32'(bus.cdb_data_valid), 32'h0);
      idle();
      for (int u = 0; u < 4; u++) begin
         tick();
         chk_cdb($sformatf("post%0d", u), 1'b1, 6'(6'h51 + u), dval(6'(6'h51 + u)));
      end
      tick();
      chk("post.end.valid", 32'(bus.cdb_data_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
